// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: pipelined 2**SEL_W : 1 word multiplexer built as a binary
// tree of 2:1 levels, with a register after every PIPE_EVERY levels.
// Stage j resolves select bits [j*PIPE_EVERY, min((j+1)*PIPE_EVERY, SEL_W)).
// The LSBs are resolved first, so each stage only carries the candidates that
// are still possible.
// The whole pipeline advances or stalls together. It advances when the output
// is empty or is being consumed.
// Optional feature macro: MUX_TREE_RR_SEL_EN. When it is defined, an internal
// round-robin pointer replaces in_sel as the select source.
module mux_tree_pipe #(
  parameter int WIDTH      = 32,
  parameter int SEL_W      = 4,
  parameter int PIPE_EVERY = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [(2**SEL_W)*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]            in_sel,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [SEL_W-1:0]            out_sel,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int STAGES = (SEL_W + PIPE_EVERY - 1) / PIPE_EVERY;

  // Global stall: every stage shifts together when the output slot is free.
  logic w_advance;
  assign w_advance = ~out_valid | out_ready;
  assign in_ready  = w_advance;

  // Select index that enters stage 0 together with the data.
  logic [SEL_W-1:0] w_sel_src;

`ifdef MUX_TREE_RR_SEL_EN
  logic [SEL_W-1:0] r_rr_ptr;
  logic             w_unused_sel;

  // Round-robin pointer: steps (mod N) on every accepted input transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (in_valid && w_advance) begin
      r_rr_ptr <= r_rr_ptr + SEL_W'(1);
    end
  end

  assign w_sel_src    = r_rr_ptr;
  assign w_unused_sel = ^in_sel;
`else
  assign w_sel_src = in_sel;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO   = gi * PIPE_EVERY;
      localparam int HI   = ((gi + 1) * PIPE_EVERY < SEL_W) ? (gi + 1) * PIPE_EVERY : SEL_W;
      localparam int NB   = HI - LO;
      localparam int CIN  = 2**(SEL_W - LO);
      localparam int COUT = 2**(SEL_W - HI);

      logic                  w_valid_in;
      logic [CIN*WIDTH-1:0]  w_cand_in;
      logic [SEL_W-1:0]      w_sel_in;
      logic [NB-1:0]         w_bits;
      logic [COUT*WIDTH-1:0] w_cand_next;

      // The full original select is kept in each stage. Its upper bits are
      // the select bits that are still unresolved, and the whole value
      // becomes out_sel at the end of the pipeline.
      logic                  r_valid;
      logic [COUT*WIDTH-1:0] r_cand;
      logic [SEL_W-1:0]      r_sel;

      if (gi == 0) begin : g_src
        assign w_valid_in = in_valid;
        assign w_cand_in  = in_data;
        assign w_sel_in   = w_sel_src;
      end else begin : g_src
        assign w_valid_in = g_stage[gi-1].r_valid;
        assign w_cand_in  = g_stage[gi-1].r_cand;
        assign w_sel_in   = g_stage[gi-1].r_sel;
      end

      assign w_bits = w_sel_in[HI-1:LO];

      // NB tree levels collapsed into one 2**NB:1 pick per surviving candidate.
      always_comb begin
        w_cand_next = '0;
        for (int k = 0; k < COUT; k++) begin
          w_cand_next[k*WIDTH +: WIDTH] = w_cand_in[(k * (2**NB) + int'(w_bits)) * WIDTH +: WIDTH];
        end
      end

      // Stage register: the valid bit always shifts on advance. The payload is
      // loaded only behind a valid bit, so bubbles leave the old data in place.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_valid <= 1'b0;
          r_cand  <= '0;
          r_sel   <= '0;
        end else if (w_advance) begin
          r_valid <= w_valid_in;
          if (w_valid_in) begin
            r_cand <= w_cand_next;
            r_sel  <= w_sel_in;
          end
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[STAGES-1].r_valid;
  assign out_data  = g_stage[STAGES-1].r_cand;
  assign out_sel   = g_stage[STAGES-1].r_sel;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Testbench for mux_tree_pipe. The main instance uses WIDTH=32, SEL_W=4 and
// PIPE_EVERY=2. Two corner instances use SEL_W=1/PIPE_EVERY=1 and
// SEL_W=5/PIPE_EVERY=2.
// Accepted transfers are queued as expected results. A monitor pops and
// compares them whenever the main DUT delivers an output.
`timescale 1ns/1ps
module tb_mux_tree_pipe;
  localparam int W   = 32;
  localparam int SW  = 4;
  localparam int N   = 16;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*W-1:0] in_data;
  logic [SW-1:0] in_sel;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_sel;

  // Corner instance A: SEL_W=1, PIPE_EVERY=1, WIDTH=8.
  logic [15:0] c1_data;
  logic        c1_sel, c1_valid, c1_ready, c1_ovalid, c1_osel;
  logic [7:0]  c1_odata;

  // Corner instance B: SEL_W=5, PIPE_EVERY=2, WIDTH=16.
  logic [32*16-1:0] c5_data;
  logic [4:0]       c5_sel, c5_osel;
  logic             c5_valid, c5_ready, c5_ovalid;
  logic [15:0]      c5_odata;

  always #5 clk = ~clk;

  mux_tree_pipe #(.WIDTH(W), .SEL_W(SW), .PIPE_EVERY(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_tree_pipe #(.WIDTH(8), .SEL_W(1), .PIPE_EVERY(1)) dut_c1 (
    .clk(clk), .rst(rst), .in_data(c1_data), .in_sel(c1_sel), .in_valid(c1_valid),
    .in_ready(c1_ready), .out_data(c1_odata), .out_sel(c1_osel),
    .out_valid(c1_ovalid), .out_ready(1'b1)
  );

  mux_tree_pipe #(.WIDTH(16), .SEL_W(5), .PIPE_EVERY(2)) dut_c5 (
    .clk(clk), .rst(rst), .in_data(c5_data), .in_sel(c5_sel), .in_valid(c5_valid),
    .in_ready(c5_ready), .out_data(c5_odata), .out_sel(c5_osel),
    .out_valid(c5_ovalid), .out_ready(1'b1)
  );

  typedef struct {
    logic [W-1:0]  data;
    logic [SW-1:0] sel;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  bit   chk_lat = 1'b0;
  bit   rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // One cycle step; inputs change 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input int s);
    bit ok;
    int n;
    in_valid = 1'b1;
    in_sel   = SW'(s);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      n++;
    end
    if (!ok) begin
      n_total++;
      $display("FAIL send_timeout: sel %0d not accepted after %0d cycles, required acceptance", s, n);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Scoreboard monitor: pops on every delivered output and pushes on every
  // accepted input. Reset discards everything that is still in flight.
  initial begin
    exp_t e;
    int   s;
    int   rr_model;
    rr_model = 0;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready && !rst) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: got sel %0d data %h, required no output", out_sel, out_data);
        end else begin
          e = q.pop_front();
          $display("out: sel=%0d data=%h (expected sel=%0d data=%h)", out_sel, out_data, e.sel, e.data);
          chk("out_data", 64'(out_data), 64'(e.data));
          chk("out_sel", 64'(out_sel), 64'(e.sel));
          if (chk_lat) chk("latency", 64'(cyc - e.cyc), 64'(LAT));
        end
      end
      if (rst) begin
        q.delete();
        rr_model = 0;
      end else if (in_valid && in_ready) begin
`ifdef MUX_TREE_RR_SEL_EN
        s = rr_model;
        rr_model = (rr_model + 1) % N;
`else
        s = int'(in_sel);
`endif
        q.push_back('{W'(32'hA000_0000 + s), SW'(s), cyc});
      end
    end
  end

  int c1_rr = 0;
  int c5_rr = 0;

  task automatic corner1(input int s);
    int n;
    int idx;
    c1_valid = 1'b1;
    c1_sel   = 1'(s);
    chk("c1_in_ready", 64'(c1_ready), 64'(1));
    tick();
    c1_valid = 1'b0;
    n = 1;
    while (!c1_ovalid && n < 10) begin
      tick();
      n++;
    end
`ifdef MUX_TREE_RR_SEL_EN
    idx = c1_rr;
    c1_rr = (c1_rr + 1) % 2;
`else
    idx = s;
`endif
    $display("c1: sel=%0d data=%h latency=%0d", c1_osel, c1_odata, n);
    chk("c1_latency", 64'(n), 64'(1));
    chk("c1_data", 64'(c1_odata), (idx == 1) ? 64'h A5 : 64'h5A);
    chk("c1_sel", 64'(c1_osel), 64'(idx));
    tick();
  endtask

  task automatic corner5(input int s);
    int n;
    int idx;
    c5_valid = 1'b1;
    c5_sel   = 5'(s);
    chk("c5_in_ready", 64'(c5_ready), 64'(1));
    tick();
    c5_valid = 1'b0;
    n = 1;
    while (!c5_ovalid && n < 10) begin
      tick();
      n++;
    end
`ifdef MUX_TREE_RR_SEL_EN
    idx = c5_rr;
    c5_rr = (c5_rr + 1) % 32;
`else
    idx = s;
`endif
    $display("c5: sel=%0d data=%h latency=%0d", c5_osel, c5_odata, n);
    chk("c5_latency", 64'(n), 64'(3));
    chk("c5_data", 64'(c5_odata), 64'(16'hC000 + idx));
    chk("c5_sel", 64'(c5_osel), 64'(idx));
    tick();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_sel = '0;
    out_ready = 1'b1;
    c1_valid = 1'b0;
    c1_sel = 1'b0;
    c5_valid = 1'b0;
    c5_sel = '0;
    c1_data = {8'hA5, 8'h5A};
    for (int k = 0; k < N; k++) in_data[k*W +: W] = W'(32'hA000_0000 + k);
    for (int k = 0; k < 32; k++) c5_data[k*16 +: 16] = 16'(16'hC000 + k);

    // Reset state.
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_sel", 64'(out_sel), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    tick();

    // Select sweep, back to back, with the latency checked.
    chk_lat = 1'b1;
    for (int s = 0; s < N; s++) send(s);
    idle(LAT + 2);

    // Stall: hold the output while a third transfer waits at the input.
    chk_lat = 1'b0;
    out_ready = 1'b0;
    send(3);
    send(7);
    in_valid = 1'b1;
    in_sel = SW'(12);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      chk("stall_out_valid", 64'(out_valid), 64'(1));
`ifdef MUX_TREE_RR_SEL_EN
      chk("stall_out_data", 64'(out_data), 64'(32'hA000_0000));
`else
      chk("stall_out_data", 64'(out_data), 64'(32'hA000_0003));
`endif
      tick();
    end
    out_ready = 1'b1;
    send(12);
    idle(4);

    // Bubbles: valid pattern 1,0,1,0.
    chk_lat = 1'b1;
    send(5);
    idle(1);
    send(10);
    idle(1);
    idle(4);

    // Random selects with random back-pressure.
    chk_lat = 1'b0;
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) != 0) send(int'($urandom_range(0, N - 1)));
      else idle(1);
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    idle(6);

    // Reset mid-stream with transfers in flight.
    send(1);
    send(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_out_data", 64'(out_data), 64'(0));
    chk("midrst_out_sel", 64'(out_sel), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    idle(6);
    send(9);
    idle(4);

    // Parameter corners.
    corner1(0);
    corner1(1);
    corner5(0);
    corner5(17);
    corner5(31);

    n = 0;
    while (q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("queue_drained", 64'(q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mux_tree_pipe.md
Name: mux_tree_pipe

Overview:
- Parametrised, pipelined N:1 word multiplexer: 2**SEL_W inputs of WIDTH bits each, built as a binary tree of 2:1 levels.
- A pipeline register is inserted after every PIPE_EVERY tree levels.
- Valid/ready handshake with global stall; throughput of one selection per cycle.
- Used for wide datapath selection (result/forwarding select) where a flat 16:1 is too slow for timing.

Parameters:
- WIDTH, 32, data bits per input and output.
- SEL_W, 4, select width; number of inputs N = 2**SEL_W; legal range 1..6.
- PIPE_EVERY, 2, tree levels per pipeline stage; legal range 1..SEL_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_data  input  N*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  index of the input to forward.
- in_valid  input  1  in_data/in_sel are presented.
- in_ready  output  1  block accepts a transfer this cycle.
- out_data  output  WIDTH  selected word.
- out_sel  output  SEL_W  select index that produced out_data.
- out_valid  output  1  out_data/out_sel are valid.
- out_ready  input  1  downstream consumes out_data this cycle.

Behaviour:
- Stages: S = ceil(SEL_W / PIPE_EVERY); latency = S cycles from acceptance to out_valid.
- Stage j resolves select bits [j*PIPE_EVERY, min((j+1)*PIPE_EVERY, SEL_W)), LSB first.
  - The lower levels of the tree resolve the LSBs, so each of the 2**(SEL_W-j*PIPE_EVERY) candidates at stage j is already narrowed.
  - The remaining upper select bits travel with the data.
- Each stage holds: valid bit, surviving candidate words, remaining select bits, and the full original select (used for out_sel).
- advance = ~out_valid | out_ready. This is a global stall: all stages shift together or all hold.
- in_ready = advance (combinational; no dependence on in_valid).
- Transfer in: in_valid & in_ready.
- When advance = 1:
  - Each stage loads the previous stage's valid bit.
  - Data and select registers load only if the incoming valid bit is 1; otherwise they hold their old values.
- When advance = 0: every register holds.
- out_data and out_sel hold stable while out_valid & ~out_ready.
- Bubbles: a cycle with in_valid = 0 inserts a bubble. Bubbles collapse only at the output (out_valid = 0 allows advance); no intermediate bubble squeezing.
- Full pipeline with out_ready = 1 and in_valid = 1 sustains 1 transfer/cycle.
- Reset (including mid-stream): all valid bits, out_valid, out_data and out_sel go to 0 on the next edge; in-flight data is discarded. in_ready = 1 in the first cycle after reset.
- Select values: every value 0..N-1 is legal (no out-of-range case). in_sel = N-1 wraps nothing.
- Selection is purely by index: identical data on several inputs is not special-cased.
- SEL_W = PIPE_EVERY gives a single registered stage (latency 1).

Optional Feature:
- Macro: MUX_TREE_RR_SEL_EN.
- Defined:
  - An internal SEL_W-bit counter rr_ptr replaces in_sel; in_sel is ignored.
  - rr_ptr resets to 0 and increments by 1 (mod N) on each accepted input transfer; it holds on cycles with no transfer.
  - out_sel reports the rr_ptr value that was used.
- Not defined: select comes from in_sel; no counter is instantiated.

Test Plan:
- Sel sweep: WIDTH = 32, SEL_W = 4, PIPE_EVERY = 2; input k = 32'hA000_0000 + k; in_sel = 0..15 back-to-back, out_ready = 1 -> out_data = A000_0000..A000_000F on consecutive cycles starting 2 cycles after the first accept; out_sel = 0..15.
- Stall: 3 transfers (sel 3, 7, 12), then out_ready = 0 for 5 cycles -> out_data holds input 3's word, out_valid = 1, in_ready = 0; on release the outputs are 3, 7, 12 in order with none lost or duplicated.
- Bubbles: in_valid pattern 1,0,1,0 with out_ready = 1 -> out_valid pattern 1,0,1,0 delayed by 2 cycles; out_data matches each accepted select.
- Reset mid-stream: assert rst for 1 cycle while 2 transfers are in flight -> out_valid = 0, out_data = 0, out_sel = 0 next cycle; no stale outputs appear afterwards.
- Parameter corners: SEL_W = 1, PIPE_EVERY = 1 (latency 1); SEL_W = 5, PIPE_EVERY = 2 (latency 3); randomized sel against a reference model -> zero mismatches over 10k transfers.
- RR feature (MUX_TREE_RR_SEL_EN defined): 20 accepts with in_sel tied to 9 -> out_sel = 0,1,...,15,0,1,2,3; a stall cycle with no transfer does not increment rr_ptr.
